pc_unit: RTL and testbench

//  Program-counter stage directly downstream of the branch comparator. It consumes take_branch plus

---
 rtl/pc_unit.sv | 100 ++++++++++
 tb/tb_pc_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: next-PC select, fetch handshake and misaligned-target trap.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   take_branch          branch comparator result
//   is_jal, is_jalr      jump decode
//   imm, rs1_data        target operands
//   stall, imem_ready    advance qualifiers
//   pc, pc_plus4         fetch address and link value
//   fetch_valid, trap    handshake valid, one-cycle trap pulse
//   trap_pc              PC of the faulting instruction
//   taken_count          retired redirect counter
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        take_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        stall,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] taken_count
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    TRAP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        advance;
  logic        redirect;
  logic        misalign;
  logic [31:0] target;
  logic [31:0] jalr_sum;

  assign pc_plus4    = pc + 32'd4;
  assign fetch_valid = (state == RUN);
  assign trap        = (state == TRAP);

  assign advance  = imem_ready & ~stall;
  assign redirect = is_jalr | is_jal | take_branch;
  assign jalr_sum = rs1_data + imm;

  always_comb begin
    target = pc_plus4;
    if (is_jalr)
      target = {jalr_sum[31:1], 1'b0};
    else if (is_jal || take_branch)
      target = pc + imm;
  end

  // jalr target bit 0 is already cleared, so
  // only bit 1 can fault on that path.
  assign misalign = redirect & (|target[1:0]);

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:    state_nx = RUN;
      RUN:     if (advance && misalign)
                 state_nx = TRAP;
      TRAP:    state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      trap_pc     <= 32'h0;
      taken_count <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == TRAP) begin
        pc <= TRAP_VECTOR;
      end else if (state == RUN && advance) begin
        if (misalign) begin
          trap_pc <= pc;
        end else begin
          pc <= target;
          if (redirect)
            taken_count <= taken_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random checks of pc_unit
// against a spec-level reference model.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        take_branch = 1'b0;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic [31:0] imm = 32'h0;
  logic [31:0] rs1_data = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] taken_count;

  int tests = 0;
  int fails = 0;

  // reference model: mode 0 = boot, 1 = running, 2 = trapping
  int          m_mode = 0;
  logic [31:0] m_pc   = RV;
  logic [31:0] m_cnt  = 0;
  logic [31:0] m_tpc  = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .take_branch(take_branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .stall      (stall),
    .imem_ready (imem_ready),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fetch_valid(fetch_valid),
    .trap       (trap),
    .trap_pc    (trap_pc),
    .taken_count(taken_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    bit red;
    if (rst) begin
      m_mode = 0; m_pc = RV; m_cnt = 0; m_tpc = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_mode = 1; m_pc = TV;
    end else if (imem_ready && !stall) begin
      red = is_jalr || is_jal || take_branch;
      if (is_jalr)
        tgt = (rs1_data + imm) & 32'hFFFF_FFFE;
      else if (is_jal || take_branch)
        tgt = m_pc + imm;
      else
        tgt = m_pc + 4;
      if (red && (tgt % 4 != 0)) begin
        m_mode = 2; m_tpc = m_pc;
      end else begin
        m_pc = tgt;
        if (red) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 4);
    chk("fetch_valid", {31'h0, fetch_valid},
        {31'h0, m_mode == 1});
    chk("trap", {31'h0, trap}, {31'h0, m_mode == 2});
    chk("trap_pc", trap_pc, m_tpc);
    chk("taken_count", taken_count, m_cnt);
  endtask

  // one clock: drive inputs, step model, check after edge
  task automatic cyc(input bit r, input bit br,
                     input bit jal, input bit jalr,
                     input logic [31:0] im,
                     input logic [31:0] rs1,
                     input bit st, input bit rdy);
    @(negedge clk);
    rst = r; take_branch = br; is_jal = jal;
    is_jalr = jalr; imm = im; rs1_data = rs1;
    stall = st; imem_ready = rdy;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // 1: reset and boot
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'h0, fetch_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("boot_fv", {31'h0, fetch_valid}, 32'h1);
    chk("boot_pc", pc, 32'h0);
    // 2: sequential
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("seq_pc4", pc, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("seq_pc8", pc, 32'h8);
    // 3: forward and backward branch
    cyc(0, 1, 0, 0, 32'h10, 0, 0, 1);
    chk("br_fwd", pc, 32'h18);
    chk("br_cnt1", taken_count, 32'h1);
    cyc(0, 1, 0, 0, 32'hFFFF_FFF8, 0, 0, 1);
    chk("br_back", pc, 32'h10);
    chk("br_cnt2", taken_count, 32'h2);
    // 4: misaligned jalr
    cyc(0, 0, 0, 1, 32'h0, 32'h103, 0, 1);
    chk("trap_pulse", {31'h0, trap}, 32'h1);
    chk("trap_pc", trap_pc, 32'h10);
    chk("trap_cnt", taken_count, 32'h2);
    cyc(0, 1, 1, 0, 32'h40, 0, 0, 1);
    chk("trap_vec", pc, 32'h100);
    chk("trap_drop", {31'h0, trap}, 32'h0);
    // 5: held by stall and imem_ready
    cyc(0, 1, 0, 0, 32'h20, 0, 1, 1);
    cyc(0, 1, 0, 0, 32'h20, 0, 1, 1);
    cyc(0, 1, 0, 0, 32'h20, 0, 0, 0);
    chk("hold_pc", pc, 32'h100);
    chk("hold_cnt", taken_count, 32'h2);
    cyc(0, 1, 0, 0, 32'h20, 0, 0, 1);
    chk("adv_pc", pc, 32'h120);
    // 6: wrap and reset during trap
    cyc(0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 0, 1);
    chk("jalr_hi", pc, 32'hFFFF_FFFC);
    chk("p4_wrap", pc_plus4, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("pc_wrap", pc, 32'h0);
    cyc(0, 0, 0, 1, 32'h0, 32'h2, 0, 1);
    chk("trap2", {31'h0, trap}, 32'h1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_trap_pc", pc, 32'h0);
    chk("rst_trap", {31'h0, trap}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    // random
    for (int i = 0; i < 500; i++) begin
      logic [31:0] rim;
      logic [31:0] rrs;
      rim = $urandom_range(0, 255) << 2;
      if ($urandom_range(0, 1) == 1) rim = -rim;
      if ($urandom_range(0, 7) == 0)
        rim = rim | $urandom_range(1, 3);
      rrs = $urandom;
      if ($urandom_range(0, 3) != 0)
        rrs = rrs & 32'hFFFF_FFFC;
      cyc($urandom_range(0, 49) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0,
          rim, rrs,
          $urandom_range(0, 4) == 0,
          $urandom_range(0, 4) != 0);
    end
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
